// File: rtl/obuf_deskew4.sv
// Output de-skew collector for the 4x4 systolic MAC array: per-row capture into a
// ping-pong tile buffer, aligned drain of one vector per beat over valid/ready.
module obuf_deskew4 #(
  parameter int DW   = 16,
  parameter int ROWS = 4,
  parameter int NCOL = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [ROWS*DW-1:0] MAC_DATA,
  input  logic [ROWS-1:0]    MAC_VALID,
  input  logic               CLR,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [ROWS*DW-1:0] OUT_DATA,
  output logic               OUT_LAST,
  output logic               OVF,
  output logic               BUSY
);

  localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NCOL - 1);

  logic [DW-1:0]        bank [2][ROWS][NCOL];
  logic [CW-1:0]        wcnt [ROWS];
  logic [ROWS-1:0]      wbank;
  logic [1:0][ROWS-1:0] done;
  logic                 rb;
  logic [CW-1:0]        rd_idx;
  logic                 ovf_q;

  logic [DW-1:0]   mac_row [ROWS];
  logic [ROWS-1:0] wr_en;
  logic [ROWS-1:0] drop;
  logic            fire;
  logic            last_fire;
  logic            permit;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    OUT_VALID = &done[rb];
    OUT_LAST  = OUT_VALID && (rd_idx == LAST_IDX);
    fire      = OUT_VALID && OUT_READY;
    last_fire = fire && (rd_idx == LAST_IDX);
    OUT_DATA  = '0;
    wr_en     = '0;
    drop      = '0;
    permit    = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      mac_row[r] = MAC_DATA[(ROWS-1-r)*DW +: DW];
      // A full row slot may still be written if its bank is released this very cycle.
      permit   = !done[wbank[r]][r] || (last_fire && (wbank[r] == rb));
      wr_en[r] = MAC_VALID[r] && permit;
      drop[r]  = MAC_VALID[r] && !permit;
      if (OUT_VALID) OUT_DATA[(ROWS-1-r)*DW +: DW] = bank[rb][r][rd_idx];
    end
  end

  always_comb begin
    BUSY = |done;
    for (int r = 0; r < ROWS; r++) begin
      if (wcnt[r] != '0) BUSY = 1'b1;
    end
  end

  assign OVF = ovf_q;

  // NOTE: state uses non-blocking assignments only; the release clear of done[rb]
  // comes before the capture loop so a completing capture's set wins the same bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < ROWS; r++) wcnt[r] <= '0;
      wbank  <= '0;
      done   <= '0;
      rb     <= 1'b0;
      rd_idx <= '0;
      ovf_q  <= 1'b0;
    end else if (CLR) begin
      for (int r = 0; r < ROWS; r++) wcnt[r] <= '0;
      wbank  <= '0;
      done   <= '0;
      rb     <= 1'b0;
      rd_idx <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (last_fire) begin
        done[rb] <= '0;
        rb       <= ~rb;
        rd_idx   <= '0;
      end else if (fire) begin
        rd_idx <= rd_idx + CW'(1);
      end
      for (int r = 0; r < ROWS; r++) begin
        if (wr_en[r]) begin
          if (wcnt[r] == LAST_IDX) begin
            done[wbank[r]][r] <= 1'b1;
            wcnt[r]           <= '0;
            wbank[r]          <= ~wbank[r];
          end else begin
            wcnt[r] <= wcnt[r] + CW'(1);
          end
        end
      end
      if (|drop) ovf_q <= 1'b1;
    end
  end

  // NOTE: the tile storage has no reset; its content is only observable behind done bits.
  always_ff @(posedge CLK) begin
    for (int r = 0; r < ROWS; r++) begin
      if (wr_en[r]) bank[wbank[r]][r][wcnt[r]] <= mac_row[r];
    end
  end

endmodule

// File: doc/obuf_deskew4.md
Name: obuf_deskew4

Overview:
- Output-side collector for the 4x4 systolic MAC array. Consumes the array's 64-bit partial-sum bus and its per-row valid bits.
- Each array row emits results skewed in time. This block captures them per row into a ping-pong tile buffer, de-skews them, and drains one aligned output vector per beat over a valid/ready handshake.
- Sits between the array outputs and the downstream result writer.

Parameters:
DW, 16, psum width per row (signed, passed through unmodified)
ROWS, 4, array rows = lanes on input and output bus
NCOL, 4, result vectors per tile (beats per drained tile), >=1

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  asynchronous active-high reset
MAC_DATA  input  ROWS*DW  row r psum at [ROWS*DW-1-r*DW -: DW]
MAC_VALID  input  ROWS  bit r qualifies row r slice this cycle
CLR  input  1  synchronous flush: all buffer state to reset values, OVF cleared
OUT_VALID  output  1  aligned vector available
OUT_READY  input  1  downstream accepts when high with OUT_VALID
OUT_DATA  output  ROWS*DW  lane r = row r result for vector index rd_idx, same packing as MAC_DATA
OUT_LAST  output  1  high with OUT_VALID on beat NCOL-1 of a tile
OVF  output  1  sticky overflow: a valid row sample was dropped
BUSY  output  1  any bank holds any captured data

Behaviour:
Reset (RST async, or CLR sync):
- All outputs 0. Storage content don't-care.
- Row counters wcnt[r]=0, per-row bank select wbank[r]=0, done[b][r]=0, rb=0, rd_idx=0.

Storage:
- bank[2][ROWS][NCOL] of DW bits.
- done[b][r] marks row r of bank b complete.

Capture, per row r, independent of other rows:
- Trigger: MAC_VALID[r]=1 and write permitted.
- Write permitted when done[wbank[r]][r]==0, or that bank is being released this same cycle (release bypass).
- Action: bank[wbank[r]][r][wcnt[r]] <= slice r; wcnt[r]++.
- When wcnt[r] reaches NCOL-1 and a write occurs: done[wbank[r]][r] <= 1, wcnt[r] <= 0, wbank[r] toggles.
- Rows may therefore sit in different banks. Row 0 can start tile k+1 while row 3 is still finishing tile k.
- MAC_VALID[r]=1 and not permitted: sample dropped, counters unchanged, OVF <= 1 (sticky until RST/CLR).

Drain:
- OUT_VALID = &done[rb] (combinational from registers).
- OUT_DATA lane r = bank[rb][r][rd_idx] while OUT_VALID, else 0.
- OUT_LAST = OUT_VALID && rd_idx==NCOL-1.
- Handshake fires on OUT_VALID && OUT_READY: rd_idx++.
- On the LAST handshake: rd_idx <= 0, done[rb][*] <= 0 (bank released), rb toggles.
- OUT_DATA/OUT_VALID hold stable while OUT_VALID && !OUT_READY.
- Latency: a tile becomes visible the cycle after its last row's final write (registered done). Earliest first handshake is that cycle.

Simultaneous events:
- Release and a capture into the same bank/row in one cycle: capture succeeds, done stays set only if that capture completes the row (NCOL=1 case), otherwise cleared.
- CLR has priority over capture and drain in its cycle.
- Reset mid-tile discards partial data; no spurious OUT_VALID afterward.

BUSY = |done | (any wcnt[r]!=0).
No arithmetic is performed; psums are copied bit-exact (sign preserved).

Test Plan:
- Aligned fill: MAC_VALID=4'hF for 4 cycles, row r value = 16*r+k on cycle k, OUT_READY=1 -> 4 beats, beat k OUT_DATA={k,16+k,32+k,48+k}, OUT_LAST on beat 3, OVF=0.
- Systolic skew: row r valid on cycles r..r+3 with value 0x100*r+k -> OUT_VALID first high cycle 7, beats identical to aligned ordering; BUSY=0 after beat 3.
- Back-to-back tiles with skew and OUT_READY=1: 8 consecutive skewed vectors -> 8 beats, two OUT_LAST pulses, no OVF; verifies per-row wbank split.
- Backpressure overflow: OUT_READY=0, feed 3 full aligned tiles -> OUT_VALID held with tile 0 beat 0 stable; tile 2 samples dropped, OVF=1. Then OUT_READY=1 -> exactly 8 beats (tiles 0,1) in order.
- Release bypass: both banks full, OUT_READY=1; row 0 sample arrives in the cycle bank 0's LAST beat fires -> sample captured into bank 0, OVF stays 0.
- Reset/CLR mid-tile: 2 of 4 vectors captured, pulse RST (async, mid-cycle) -> all outputs 0 immediately; then a fresh full tile drains correctly. Repeat with CLR -> same, OVF cleared.
